// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the synchronous instruction memory, tracks the PC,
// absorbs one in-flight return in a skid buffer under stall and flushes on jump redirect.
module fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    INSN_WIDTH   = 32,
    parameter int                    OP_CODE_BITS = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = {ADDR_WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic                    imem_rd_en,
    input  logic [INSN_WIDTH-1:0]   imem_rdata,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    if_valid,
    output logic [ADDR_WIDTH-1:0]   if_pc,
    output logic [INSN_WIDTH-1:0]   if_instruction,
    output logic [OP_CODE_BITS-1:0] if_opcode
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic                    r_req_valid;
    logic [ADDR_WIDTH-1:0]   r_req_pc;
    logic                    r_skid_valid;
    logic [ADDR_WIDTH-1:0]   r_skid_pc;
    logic [INSN_WIDTH-1:0]   r_skid_insn;
    logic                    r_if_valid;
    logic [ADDR_WIDTH-1:0]   r_if_pc;
    logic [INSN_WIDTH-1:0]   r_if_insn;
    logic                    w_rd_en;

    // No read is issued while stalled, so at most one return can land in the skid.
    assign w_rd_en        = ~reset & ~stall & ~redirect;
    assign imem_rd_en     = w_rd_en;
    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_insn;
    assign if_opcode      = r_if_insn[INSN_WIDTH-1 -: OP_CODE_BITS];

    // PC, outstanding-read tracking, skid buffer and decode-facing output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_req_valid  <= 1'b0;
            r_req_pc     <= {ADDR_WIDTH{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_pc    <= {ADDR_WIDTH{1'b0}};
            r_skid_insn  <= {INSN_WIDTH{1'b0}};
            r_if_valid   <= 1'b0;
            r_if_pc      <= {ADDR_WIDTH{1'b0}};
            r_if_insn    <= {INSN_WIDTH{1'b0}};
        end else begin
            r_req_valid <= w_rd_en;
            r_req_pc    <= r_pc;
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_rd_en) begin
                r_pc <= r_pc + ADDR_WIDTH'(1);
            end else begin
                r_pc <= r_pc;
            end

            if (redirect) begin
                r_if_valid   <= 1'b0;
                r_if_insn    <= {INSN_WIDTH{1'b0}};
                r_skid_valid <= 1'b0;
            end else if (stall) begin
                if (r_req_valid && !r_skid_valid) begin
                    r_skid_insn  <= imem_rdata;
                    r_skid_pc    <= r_req_pc;
                    r_skid_valid <= 1'b1;
                end
            end else if (r_skid_valid) begin
                r_if_valid   <= 1'b1;
                r_if_pc      <= r_skid_pc;
                r_if_insn    <= r_skid_insn;
                r_skid_valid <= 1'b0;
            end else if (r_req_valid) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_pc;
                r_if_insn  <= imem_rdata;
            end else begin
                r_if_valid <= 1'b0;
                r_if_insn  <= {INSN_WIDTH{1'b0}};
            end
        end
    end

    // Fetch control state: skid occupancy and pending redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect)                 r_state <= ST_REDIR;
                    else if (stall && r_req_valid) r_state <= ST_HOLD;
                    else                          r_state <= ST_RUN;
                end
                ST_HOLD: begin
                    if (redirect)    r_state <= ST_REDIR;
                    else if (!stall) r_state <= ST_RUN;
                    else             r_state <= ST_HOLD;
                end
                ST_REDIR: begin
                    if (redirect)    r_state <= ST_REDIR;
                    else if (!stall) r_state <= ST_RUN;
                    else             r_state <= ST_REDIR;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, stall/skid, redirect under stall,
// PC wrap, reset while holding, and back-to-back redirects.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [31:0] if_instruction;
    logic [5:0]  if_opcode;

    logic        reset2, zero_in;
    logic [15:0] zero_pc;
    logic [15:0] imem_addr2;
    logic        imem_rd_en2;
    logic [31:0] imem_rdata2 = 32'h0000_0000;
    logic        if_valid2;
    logic [15:0] if_pc2;
    logic [31:0] if_instruction2;
    logic [5:0]  if_opcode2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction), .if_opcode(if_opcode)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2),
        .imem_rdata(imem_rdata2), .stall(zero_in), .redirect(zero_in), .redirect_pc(zero_pc),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instruction(if_instruction2), .if_opcode(if_opcode2)
    );

    // Synchronous instruction memories: imem[i] = 0x04000000 | i.
    always @(posedge clk) begin
        if (imem_rd_en)  imem_rdata  <= 32'h0400_0000 | {16'h0000, imem_addr};
        if (imem_rd_en2) imem_rdata2 <= 32'h0400_0000 | {16'h0000, imem_addr2};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] pc);
        chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_pc"}, {16'd0, if_pc}, {16'd0, pc});
            chk({tag, "_insn"}, if_instruction, 32'h0400_0000 | {16'd0, pc});
            chk({tag, "_op"}, {26'd0, if_opcode}, 32'd1);
        end else begin
            chk({tag, "_insn0"}, if_instruction, 32'd0);
            chk({tag, "_op0"}, {26'd0, if_opcode}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        reset2 = 1'b1; zero_in = 1'b0; zero_pc = 16'h0000;
        tick(); tick();
        // Reset state
        chk_out("rst", 1'b0, 16'h0000);
        chk("rst_if_pc", {16'd0, if_pc}, 32'd0);
        chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, 32'd0);
        chk("rst2_addr", {16'd0, imem_addr2}, 32'h0000_FFFE);
        chk("rst2_valid", {31'd0, if_valid2}, 32'd0);

        // T1: startup stream
        reset = 1'b0; #1;
        chk("t1_rd_en", {31'd0, imem_rd_en}, 32'd1);
        chk("t1_addr0", {16'd0, imem_addr}, 32'd0);
        tick(); chk_out("t1_e1", 1'b0, 16'h0000);
        chk("t1_addr1", {16'd0, imem_addr}, 32'd1);
        tick(); chk_out("t1_e2", 1'b1, 16'h0000);
        tick(); chk_out("t1_e3", 1'b1, 16'h0001);
        tick(); chk_out("t1_e4", 1'b1, 16'h0002);

        // T2: stall 3 cycles while showing pc 2
        stall = 1'b1; #1;
        chk("t2_rd_en_off", {31'd0, imem_rd_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("t2_hold", 1'b1, 16'h0002);
            chk("t2_skid", {31'd0, dut.r_skid_valid}, 32'd1);
            chk("t2_rd_en_hold", {31'd0, imem_rd_en}, 32'd0);
        end
        stall = 1'b0;
        tick(); chk_out("t2_rel3", 1'b1, 16'h0003);
        tick(); chk_out("t2_rel4", 1'b1, 16'h0004);
        tick(); chk_out("t2_rel5", 1'b1, 16'h0005);

        // T3: redirect to 0x40 while stalled
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        tick(); chk_out("t3_flush", 1'b0, 16'h0000);
        redirect = 1'b0; redirect_pc = 16'h0000;
        tick(); chk_out("t3_stall1", 1'b0, 16'h0000);
        tick(); chk_out("t3_stall2", 1'b0, 16'h0000);
        chk("t3_addr", {16'd0, imem_addr}, 32'h0000_0040);
        stall = 1'b0;
        tick(); chk_out("t3_bubble", 1'b0, 16'h0000);
        tick(); chk_out("t3_tgt", 1'b1, 16'h0040);
        tick(); chk_out("t3_tgt1", 1'b1, 16'h0041);

        // T6: redirects on two consecutive cycles, last wins
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick(); chk_out("t6_r1", 1'b0, 16'h0000);
        redirect_pc = 16'h0020;
        tick(); chk_out("t6_r2", 1'b0, 16'h0000);
        redirect = 1'b0; #1;
        chk("t6_addr", {16'd0, imem_addr}, 32'h0000_0020);
        tick(); chk_out("t6_bubble", 1'b0, 16'h0000);
        tick(); chk_out("t6_tgt", 1'b1, 16'h0020);
        tick(); chk_out("t6_tgt1", 1'b1, 16'h0021);

        // T5: reset while holding a full skid
        stall = 1'b1;
        tick(); chk_out("t5_hold", 1'b1, 16'h0021);
        chk("t5_skid", {31'd0, dut.r_skid_valid}, 32'd1);
        reset = 1'b1;
        tick(); chk_out("t5_rst", 1'b0, 16'h0000);
        chk("t5_rst_pc", {16'd0, if_pc}, 32'd0);
        chk("t5_rst_addr", {16'd0, imem_addr}, 32'd0);
        chk("t5_rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        tick(); chk_out("t5_e1", 1'b0, 16'h0000);
        tick(); chk_out("t5_e2", 1'b1, 16'h0000);
        tick(); chk_out("t5_e3", 1'b1, 16'h0001);

        // T4: PC wrap from RESET_PC=0xFFFE
        reset2 = 1'b0;
        tick(); chk("t4_e1_valid", {31'd0, if_valid2}, 32'd0);
        tick(); chk("t4_pc0", {16'd0, if_pc2}, 32'h0000_FFFE);
        chk("t4_insn0", if_instruction2, 32'h0400_FFFE);
        tick(); chk("t4_pc1", {16'd0, if_pc2}, 32'h0000_FFFF);
        tick(); chk("t4_pc2", {16'd0, if_pc2}, 32'h0000_0000);
        chk("t4_valid2", {31'd0, if_valid2}, 32'd1);
        tick(); chk("t4_pc3", {16'd0, if_pc2}, 32'h0000_0001);
        chk("t4_op3", {26'd0, if_opcode2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
